// File: rtl/masked_lut_rom.sv
// -----------------------------------------------------------------------------
// masked_lut_rom
//
// A lookup table that can be written and then locked. All read channels share
// one 2^ADDR_W x DATA_W table. Each channel has a registered read stage and an
// optional output register (OUT_REG). A read sampled in the same cycle as a
// write to the same address returns the incoming write data. After wr_lock
// is pulsed, the table is write-protected until reset. Any write attempted
// after that is dropped and reported on err_wr.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset (clears pipeline/lock, not table)
//   en         read-pipeline enable; low freezes every read stage
//   req_valid  per-channel read request            [CHANNELS]
//   req_addr   per-channel read address            [CHANNELS*ADDR_W]
//   rsp_valid  per-channel response valid          [CHANNELS]
//   rsp_data   per-channel response data           [CHANNELS*DATA_W]
//   wr_en      table write strobe (ignores en)
//   wr_addr    write address
//   wr_data    write data
//   wr_lock    one-cycle request to write-protect the table
//   locked     table is write-protected
//   err_wr     one-cycle pulse for each rejected write
// -----------------------------------------------------------------------------
module masked_lut_rom #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 2,
  parameter int OUT_REG  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [CHANNELS-1:0]        req_valid,
  input  logic [CHANNELS*ADDR_W-1:0] req_addr,
  output logic [CHANNELS-1:0]        rsp_valid,
  output logic [CHANNELS*DATA_W-1:0] rsp_data,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_lock,
  output logic                       locked,
  output logic                       err_wr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] lut [DEPTH];
  logic              wr_accept;

  // A write lands only outside reset and only while the table is unlocked.
  // Reads use this same term for the write-first bypass.
  assign wr_accept = rst & wr_en & ~locked;

  // ---------------------------------------------------------------------------
  // Lock and write-error tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked <= 1'b0;
      err_wr <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments. That way every
      // flop samples the pre-edge values, whatever order the blocks run in.
      if (wr_lock) begin
        locked <= 1'b1;
      end
      // Locking takes effect on the next edge. A write in the same cycle as
      // wr_lock is therefore still accepted, and only later writes are flagged.
      err_wr <= wr_en & locked;
    end
  end

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  // NOTE: the table has no reset on purpose. Its contents must survive rst.
  // Leaving a memory array out of the reset also lets it map onto RAM instead
  // of a wall of resettable flops.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      lut[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channels
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_data;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;

    assign addr = req_addr[c*ADDR_W +: ADDR_W];

    // Write-first: a same-cycle write to this address overrides the stored
    // entry.
    always_comb begin
      // NOTE: assign a default first so that every path drives rd_data and no
      // latch is inferred.
      rd_data = lut[addr];
      if (wr_accept && (wr_addr == addr)) begin
        rd_data = wr_data;
      end
    end

    // Read stage. Valid follows the request whenever the pipe advances.
    // Data is captured only for real requests, so outputs hold their last
    // value while idle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
      end else if (en) begin
        s1_valid <= req_valid[c];
        if (req_valid[c]) begin
          s1_data <= rd_data;
        end
      end
    end

    if (OUT_REG != 0) begin : g_out_reg
      logic              o_valid;
      logic [DATA_W-1:0] o_data;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          o_valid <= 1'b0;
          o_data  <= '0;
        end else if (en) begin
          o_valid <= s1_valid;
          if (s1_valid) begin
            o_data <= s1_data;
          end
        end
      end

      assign rsp_valid[c]                = o_valid;
      assign rsp_data[c*DATA_W +: DATA_W] = o_data;
    end else begin : g_no_out_reg
      assign rsp_valid[c]                = s1_valid;
      assign rsp_data[c*DATA_W +: DATA_W] = s1_data;
    end
  end

endmodule

// File: tb/tb_masked_lut_rom.sv
// -----------------------------------------------------------------------------
// tb_masked_lut_rom
//
// Three instances share the clock, reset, enable and write port:
//   dut_a : defaults (2 channels, OUT_REG=1)
//   dut_z : 2 channels, OUT_REG=0 (shares read requests with dut_a)
//   dut_q : 4 channels, OUT_REG=1 (its own read requests)
// Inputs are driven on the falling edge and outputs are sampled there, away
// from the active rising edge.
// -----------------------------------------------------------------------------
module tb_masked_lut_rom;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_lock;

  logic [1:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  q_req_valid;
  logic [39:0] q_req_addr;

  logic [1:0]  a_rsp_valid, z_rsp_valid;
  logic [15:0] a_rsp_data, z_rsp_data;
  logic [3:0]  q_rsp_valid;
  logic [31:0] q_rsp_data;
  logic        a_locked, z_locked, q_locked;
  logic        a_err_wr, z_err_wr, q_err_wr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  masked_lut_rom dut_a (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_addr(req_addr),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lock(wr_lock),
    .locked(a_locked), .err_wr(a_err_wr)
  );

  masked_lut_rom #(.OUT_REG(0)) dut_z (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_addr(req_addr),
    .rsp_valid(z_rsp_valid), .rsp_data(z_rsp_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lock(wr_lock),
    .locked(z_locked), .err_wr(z_err_wr)
  );

  masked_lut_rom #(.CHANNELS(4)) dut_q (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(q_req_valid), .req_addr(q_req_addr),
    .rsp_valid(q_rsp_valid), .rsp_data(q_rsp_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lock(wr_lock),
    .locked(q_locked), .err_wr(q_err_wr)
  );

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_lock = 1'b0;
    req_valid = '0; req_addr = '0; q_req_valid = '0; q_req_addr = '0;
    nxt(); nxt();
    n_cmp++; if (a_rsp_valid !== 2'b00 || a_rsp_data !== 16'h0) begin n_bad++; $display("FAIL reset_a_out: got %b/%h exp 00/0000", a_rsp_valid, a_rsp_data); end
    n_cmp++; if (z_rsp_valid !== 2'b00 || z_rsp_data !== 16'h0) begin n_bad++; $display("FAIL reset_z_out: got %b/%h exp 00/0000", z_rsp_valid, z_rsp_data); end
    n_cmp++; if (q_rsp_valid !== 4'h0 || q_rsp_data !== 32'h0) begin n_bad++; $display("FAIL reset_q_out: got %h/%h exp 0/00000000", q_rsp_valid, q_rsp_data); end
    n_cmp++; if ({a_locked, z_locked, q_locked, a_err_wr, z_err_wr, q_err_wr} !== 6'b0) begin n_bad++; $display("FAIL reset_flags: got %b exp 000000", {a_locked, z_locked, q_locked, a_err_wr, z_err_wr, q_err_wr}); end
    // wr_lock must be ignored while in reset
    wr_lock = 1'b1;
    nxt();
    n_cmp++; if (a_locked !== 1'b0) begin n_bad++; $display("FAIL reset_lock_ignored: got %b exp 0", a_locked); end
    wr_lock = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    // writes land on the first edge after reset release
    wr_en = 1'b1; wr_addr = 10'h000; wr_data = 8'h63;
    nxt();
    wr_addr = 10'h3FF; wr_data = 8'h7C;
    nxt();
    wr_en = 1'b0; req_valid = 2'b11; req_addr = {10'h3FF, 10'h000};
    nxt();
    req_valid = 2'b00;
    n_cmp++; if (z_rsp_valid !== 2'b11 || z_rsp_data !== 16'h7C63) begin n_bad++; $display("FAIL basic_z_lat1: got %b/%h exp 11/7c63", z_rsp_valid, z_rsp_data); end
    n_cmp++; if (a_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL basic_a_early: got %b exp 00", a_rsp_valid); end
    nxt();
    n_cmp++; if (a_rsp_valid !== 2'b11 || a_rsp_data !== 16'h7C63) begin n_bad++; $display("FAIL basic_a_lat2: got %b/%h exp 11/7c63", a_rsp_valid, a_rsp_data); end
    n_cmp++; if (z_rsp_valid !== 2'b00 || z_rsp_data !== 16'h7C63) begin n_bad++; $display("FAIL basic_z_hold: got %b/%h exp 00/7c63", z_rsp_valid, z_rsp_data); end
    nxt();
    n_cmp++; if (a_rsp_valid !== 2'b00 || a_rsp_data !== 16'h7C63) begin n_bad++; $display("FAIL basic_a_hold: got %b/%h exp 00/7c63", a_rsp_valid, a_rsp_data); end
  endtask

  task automatic test_four_channels();
    wr_en = 1'b1; wr_addr = 10'h2A0; wr_data = 8'h5A;
    nxt();
    wr_en = 1'b0; q_req_valid = 4'hF; q_req_addr = {4{10'h2A0}};
    nxt();
    // back-to-back: mixed addresses on the next cycle
    q_req_addr = {10'h000, 10'h2A0, 10'h3FF, 10'h000};
    nxt();
    q_req_valid = 4'h0;
    n_cmp++; if (q_rsp_valid !== 4'hF || q_rsp_data !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL four_same_addr: got %h/%h exp f/5a5a5a5a", q_rsp_valid, q_rsp_data); end
    nxt();
    n_cmp++; if (q_rsp_valid !== 4'hF || q_rsp_data !== 32'h635A7C63) begin n_bad++; $display("FAIL four_mixed_addr: got %h/%h exp f/635a7c63", q_rsp_valid, q_rsp_data); end
    nxt();
    n_cmp++; if (q_rsp_valid !== 4'h0 || q_rsp_data !== 32'h635A7C63) begin n_bad++; $display("FAIL four_idle_hold: got %h/%h exp 0/635a7c63", q_rsp_valid, q_rsp_data); end
  endtask

  task automatic test_write_first();
    wr_en = 1'b1; wr_addr = 10'h055; wr_data = 8'h33;
    nxt();
    wr_data = 8'hAA; req_valid = 2'b11; req_addr = {10'h000, 10'h055};
    nxt();
    wr_en = 1'b0; req_valid = 2'b00;
    n_cmp++; if (z_rsp_valid !== 2'b11 || z_rsp_data !== 16'h63AA) begin n_bad++; $display("FAIL wfirst_z: got %b/%h exp 11/63aa", z_rsp_valid, z_rsp_data); end
    nxt();
    n_cmp++; if (a_rsp_valid !== 2'b11 || a_rsp_data !== 16'h63AA) begin n_bad++; $display("FAIL wfirst_a: got %b/%h exp 11/63aa", a_rsp_valid, a_rsp_data); end
  endtask

  task automatic test_stall();
    wr_en = 1'b1; wr_addr = 10'h010; wr_data = 8'h4C;
    nxt();
    // request held while stalled: sampled only once en returns
    wr_en = 1'b0; en = 1'b0; req_valid = 2'b01; req_addr = {10'h000, 10'h010};
    for (int i = 0; i < 3; i++) begin
      nxt();
      n_cmp++; if (a_rsp_valid !== 2'b00 || z_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL stall_pre_valid%0d: got a=%b z=%b exp 00/00", i, a_rsp_valid, z_rsp_valid); end
    end
    en = 1'b1;
    nxt();
    req_valid = 2'b00;
    n_cmp++; if (z_rsp_valid !== 2'b01 || z_rsp_data[7:0] !== 8'h4C) begin n_bad++; $display("FAIL stall_pre_z_rsp: got %b/%h exp 01/4c", z_rsp_valid, z_rsp_data[7:0]); end
    n_cmp++; if (a_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL stall_pre_a_early: got %b exp 00", a_rsp_valid); end
    nxt();
    n_cmp++; if (a_rsp_valid !== 2'b01 || a_rsp_data[7:0] !== 8'h4C) begin n_bad++; $display("FAIL stall_pre_a_rsp: got %b/%h exp 01/4c", a_rsp_valid, a_rsp_data[7:0]); end
    n_cmp++; if (z_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL stall_pre_z_once: got %b exp 00", z_rsp_valid); end
    // stall with the request already inside the pipe
    req_valid = 2'b10; req_addr = {10'h3FF, 10'h000};
    nxt();
    en = 1'b0; req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (a_rsp_valid !== 2'b00 || z_rsp_valid !== 2'b10 || z_rsp_data[15:8] !== 8'h7C) begin n_bad++; $display("FAIL stall_mid%0d: got a=%b z=%b/%h exp 00 10/7c", i, a_rsp_valid, z_rsp_valid, z_rsp_data[15:8]); end
      if (i == 3) en = 1'b1;
      nxt();
    end
    n_cmp++; if (a_rsp_valid !== 2'b10 || a_rsp_data[15:8] !== 8'h7C) begin n_bad++; $display("FAIL stall_mid_a_rsp: got %b/%h exp 10/7c", a_rsp_valid, a_rsp_data[15:8]); end
    n_cmp++; if (z_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL stall_mid_z_done: got %b exp 00", z_rsp_valid); end
    nxt();
    n_cmp++; if (a_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL stall_mid_a_done: got %b exp 00", a_rsp_valid); end
  endtask

  task automatic test_lock();
    wr_lock = 1'b1;
    nxt();
    wr_lock = 1'b0;
    n_cmp++; if (a_locked !== 1'b1 || a_err_wr !== 1'b0) begin n_bad++; $display("FAIL lock_set: got locked=%b err=%b exp 1/0", a_locked, a_err_wr); end
    wr_en = 1'b1; wr_addr = 10'h055; wr_data = 8'h11;
    nxt();
    n_cmp++; if (a_err_wr !== 1'b1 || a_locked !== 1'b1) begin n_bad++; $display("FAIL lock_err1: got err=%b locked=%b exp 1/1", a_err_wr, a_locked); end
    wr_data = 8'h22;
    nxt();
    wr_en = 1'b0;
    n_cmp++; if (a_err_wr !== 1'b1) begin n_bad++; $display("FAIL lock_err2: got %b exp 1", a_err_wr); end
    nxt();
    n_cmp++; if (a_err_wr !== 1'b0 || a_locked !== 1'b1) begin n_bad++; $display("FAIL lock_err_clear: got err=%b locked=%b exp 0/1", a_err_wr, a_locked); end
    req_valid = 2'b01; req_addr = {10'h000, 10'h055};
    nxt();
    req_valid = 2'b00;
    nxt();
    n_cmp++; if (a_rsp_valid !== 2'b01 || a_rsp_data[7:0] !== 8'hAA) begin n_bad++; $display("FAIL lock_table_kept: got %b/%h exp 01/aa", a_rsp_valid, a_rsp_data[7:0]); end
  endtask

  task automatic test_reset_midop();
    req_valid = 2'b01; req_addr = {10'h000, 10'h000};
    nxt();
    req_addr = {10'h000, 10'h3FF};
    nxt();
    n_cmp++; if (a_rsp_valid !== 2'b01 || a_rsp_data[7:0] !== 8'h63) begin n_bad++; $display("FAIL midrst_inflight: got %b/%h exp 01/63", a_rsp_valid, a_rsp_data[7:0]); end
    // reset mid-stream, with a write that must be ignored
    rst = 1'b0; req_addr = {10'h000, 10'h010};
    wr_en = 1'b1; wr_addr = 10'h055; wr_data = 8'hEE;
    #1;
    n_cmp++; if (a_rsp_valid !== 2'b00 || a_rsp_data !== 16'h0 || z_rsp_valid !== 2'b00 || z_rsp_data !== 16'h0) begin n_bad++; $display("FAIL midrst_outs: got a=%b/%h z=%b/%h exp zero", a_rsp_valid, a_rsp_data, z_rsp_valid, z_rsp_data); end
    n_cmp++; if (a_locked !== 1'b0 || a_err_wr !== 1'b0 || q_rsp_data !== 32'h0) begin n_bad++; $display("FAIL midrst_flags: got locked=%b err=%b q=%h exp 0/0/0", a_locked, a_err_wr, q_rsp_data); end
    nxt();
    rst = 1'b1; wr_en = 1'b0;
    req_valid = 2'b11; req_addr = {10'h3FF, 10'h055};
    nxt();
    req_valid = 2'b00;
    n_cmp++; if (a_rsp_valid !== 2'b00 || a_rsp_data !== 16'h0) begin n_bad++; $display("FAIL midrst_no_stale: got %b/%h exp 00/0000", a_rsp_valid, a_rsp_data); end
    n_cmp++; if (z_rsp_valid !== 2'b11 || z_rsp_data !== 16'h7CAA) begin n_bad++; $display("FAIL midrst_z_after: got %b/%h exp 11/7caa", z_rsp_valid, z_rsp_data); end
    nxt();
    n_cmp++; if (a_rsp_valid !== 2'b11 || a_rsp_data !== 16'h7CAA) begin n_bad++; $display("FAIL midrst_table_intact: got %b/%h exp 11/7caa", a_rsp_valid, a_rsp_data); end
    n_cmp++; if (a_locked !== 1'b0) begin n_bad++; $display("FAIL midrst_unlocked: got %b exp 0", a_locked); end
    nxt();
    n_cmp++; if (a_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL midrst_single_rsp: got %b exp 00", a_rsp_valid); end
  endtask

  task automatic test_write_and_lock();
    // write and lock together, with the read pipe stalled
    en = 1'b0; wr_en = 1'b1; wr_lock = 1'b1; wr_addr = 10'h200; wr_data = 8'h9D;
    nxt();
    en = 1'b1; wr_en = 1'b0; wr_lock = 1'b0;
    n_cmp++; if (a_locked !== 1'b1 || a_err_wr !== 1'b0) begin n_bad++; $display("FAIL wrlock_flags: got locked=%b err=%b exp 1/0", a_locked, a_err_wr); end
    req_valid = 2'b01; req_addr = {10'h000, 10'h200};
    nxt();
    req_valid = 2'b00;
    n_cmp++; if (z_rsp_valid !== 2'b01 || z_rsp_data[7:0] !== 8'h9D) begin n_bad++; $display("FAIL wrlock_z_data: got %b/%h exp 01/9d", z_rsp_valid, z_rsp_data[7:0]); end
    nxt();
    n_cmp++; if (a_rsp_valid !== 2'b01 || a_rsp_data[7:0] !== 8'h9D) begin n_bad++; $display("FAIL wrlock_a_data: got %b/%h exp 01/9d", a_rsp_valid, a_rsp_data[7:0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_four_channels();
    test_write_first();
    test_stall();
    test_lock();
    test_reset_midop();
    test_write_and_lock();
    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
